// File: rtl/mult_seq_32bit.sv
// mult_seq_32bit: iterative radix-2 shift-and-add 32x32->64 multiplier, signed or unsigned, start/busy/done handshake.
// Define MULT_OVF_EN to add a registered ovf output flagging products that do not fit in 32 bits.
module mult_seq_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] p_hi,
   output logic [WIDTH-1:0] p_lo,
   output logic             busy,
   output logic             done
`ifdef MULT_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
   state_t state, next;
   logic [WIDTH-1:0] m, hi, lo, s, addend;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] res;
   logic c, neg, sgn, accept;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= next;
   always_comb begin
      accept = start && (state == S_IDLE || state == S_DONE);
      busy   = state == S_RUN || state == S_FIX;
      done   = state == S_DONE;
      next   = accept ? S_RUN :
               state == S_RUN ? (cnt == CW'(WIDTH - 1) ? S_FIX : S_RUN) :
               state == S_FIX ? S_DONE : S_IDLE;
   end
   // One accumulate per iteration: the adder carry-out becomes the new top bit of hi.
   always_comb begin
      addend = lo[0] ? m : '0;
      {c, s} = {1'b0, hi} + {1'b0, addend};
      res    = neg ? ~{hi, lo} + {{(2*WIDTH-1){1'b0}}, 1'b1} : {hi, lo};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m    <= '0;
         hi   <= '0;
         lo   <= '0;
         cnt  <= '0;
         neg  <= 1'b0;
         sgn  <= 1'b0;
         p_hi <= '0;
         p_lo <= '0;
      end else if (accept) begin
         m    <= (signed_op && a[WIDTH-1]) ? -a : a;
         lo   <= (signed_op && b[WIDTH-1]) ? -b : b;
         hi   <= '0;
         cnt  <= '0;
         neg  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
         sgn  <= signed_op;
      end else if (state == S_RUN) begin
         hi   <= {c, s[WIDTH-1:1]};
         lo   <= {s[0], lo[WIDTH-1:1]};
         cnt  <= cnt + CW'(1);
      end else if (state == S_FIX) begin
         p_hi <= res[2*WIDTH-1:WIDTH];
         p_lo <= res[WIDTH-1:0];
      end
`ifdef MULT_OVF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ovf <= 1'b0;
      else if (state == S_FIX)
         ovf <= sgn ? res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}} : |res[2*WIDTH-1:WIDTH];
`endif
endmodule

// File: tb/tb_mult_seq_32bit.sv
// tb_mult_seq_32bit: scoreboard bench for mult_seq_32bit against a 64-bit arithmetic reference model.
module tb_mult_seq_32bit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic signed_op = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] p_hi, p_lo;
   logic busy, done;
`ifdef MULT_OVF_EN
   logic ovf;
`endif
   typedef struct {
      logic [63:0] p;
      logic        o;
      int          cyc;
   } exp_t;
   exp_t q[$];
   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   logic [63:0] prev_p = '0;
   mult_seq_32bit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
      .a(a), .b(b), .p_hi(p_hi), .p_lo(p_lo), .busy(busy), .done(done)
`ifdef MULT_OVF_EN
      , .ovf(ovf)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask
   function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return s ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
   endfunction
   function automatic logic model_ovf(input logic s, input logic [63:0] r);
      longint v;
      v = longint'(r);
      return s ? (v > 64'sd2147483647 || v < -64'sd2147483648) : (r > 64'h00000000FFFFFFFF);
   endfunction
   // Edge E0 is the posedge at which start is sampled; done must be visible after edge E0+33.
   task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      @(negedge clk);
      start = 1'b1; signed_op = s; a = x; b = y;
      @(posedge clk);
      #1;
      e.p = model(s, x, y);
      e.o = model_ovf(s, e.p);
      e.cyc = cyc + 33;
      q.push_back(e);
      start = 1'b0; signed_op = 1'($urandom); a = $urandom; b = $urandom;
   endtask
   task automatic op(input logic s, input logic [31:0] x, input logic [31:0] y);
      issue(s, x, y);
      repeat (35) @(negedge clk);
   endtask
   always @(negedge clk)
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("product", {p_hi, p_lo}, e.p);
            chk("latency", 64'(cyc), 64'(e.cyc));
            chk("busy_at_done", 64'(busy), 64'(0));
`ifdef MULT_OVF_EN
            chk("ovf", 64'(ovf), 64'(e.o));
`endif
            prev_p = e.p;
         end
      end
   logic [31:0] pats[8] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h00010000, 32'hDEADBEEF, 32'h55555555};
   initial begin
      int nb;
      start = 1'b1; a = $urandom; b = $urandom; signed_op = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_p_hi", 64'(p_hi), 64'(0));
      chk("rst_p_lo", 64'(p_lo), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      issue(1'b0, 32'h0000000B, 32'h0000000A);
      nb = 0;
      repeat (34) begin
         @(negedge clk);
         nb += int'(busy);
      end
      chk("busy_cycles", 64'(nb), 64'(33));
      repeat (2) @(negedge clk);
      op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      op(1'b1, 32'hFFFFFFFF, 32'h00000001);
      op(1'b1, 32'h80000000, 32'h80000000);
      op(1'b1, 32'h00000000, 32'hFFFFFFFF);
      issue(1'b0, 32'h00001234, 32'h00005678);
      repeat (5) @(negedge clk);
      chk("hold_prev_p", {p_hi, p_lo}, prev_p);
      chk("run_busy", 64'(busy), 64'(1));
      start = 1'b1; signed_op = 1'b0; a = 32'h2; b = 32'h2;
      @(negedge clk);
      start = 1'b0;
      repeat (32) @(negedge clk);
      issue(1'b1, 32'hFFFFFFF9, 32'h00000003);
      repeat (33) @(posedge clk);
      issue(1'b0, 32'h3, 32'h5);
      repeat (35) @(negedge clk);
      issue(1'b0, 32'h7, 32'h9);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_p", {p_hi, p_lo}, 64'(0));
      q.delete();
      prev_p = '0;
      @(negedge clk);
      rst_n = 1'b1;
      op(1'b0, 32'h7, 32'h6);
      for (int i = 0; i < 24; i++) begin
         logic [31:0] x, y;
         x = (i % 3 == 0) ? pats[$urandom_range(0, 7)] : $urandom;
         y = (i % 4 == 1) ? pats[$urandom_range(0, 7)] : $urandom;
         op(1'($urandom), x, y);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      chk("queue_empty", 64'(q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
